// File: rtl/beat_generator.sv
// Tempo source: emits a one-cycle beat every PERIOD enabled cycles, with bar strobe and beat-in-bar index.
// Tempo changes are held pending and take effect only on a beat boundary (or immediately on restart).
module beat_generator #(
  parameter int PERIOD_WIDTH   = 20,
  parameter int DEFAULT_PERIOD = 50000,
  parameter int BEATS_PER_BAR  = 4,
  parameter int BAR_WIDTH      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    restart,
  input  logic                    period_load,
  input  logic [PERIOD_WIDTH-1:0] period_in,
  output logic                    beat,
  output logic                    bar,
  output logic [BAR_WIDTH-1:0]    beat_index,
  output logic [PERIOD_WIDTH-1:0] period
);

  localparam logic [PERIOD_WIDTH-1:0] DEF_P    = PERIOD_WIDTH'(DEFAULT_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] MIN_P    = PERIOD_WIDTH'(2);
  localparam logic [PERIOD_WIDTH-1:0] ONE_P    = PERIOD_WIDTH'(1);
  localparam logic [BAR_WIDTH-1:0]    LAST_IDX = BAR_WIDTH'(BEATS_PER_BAR - 1);

  logic [PERIOD_WIDTH-1:0] tick_q, tick_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] pend_q, pend_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [BAR_WIDTH-1:0]    next_idx_q, next_idx_d;
  logic [BAR_WIDTH-1:0]    beat_index_q, beat_index_d;
  logic                    beat_q, beat_d;
  logic                    bar_q, bar_d;
  logic                    load_ok;
  logic                    boundary;

  assign load_ok  = period_load && (period_in >= MIN_P);
  assign boundary = enable && (tick_q == (period_q - ONE_P));

  always_comb begin
    tick_d       = tick_q;
    period_d     = period_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    next_idx_d   = next_idx_q;
    beat_index_d = beat_index_q;
    beat_d       = 1'b0;
    bar_d        = 1'b0;

    if (restart) begin
      tick_d     = '0;
      next_idx_d = '0;
      // A same-cycle load is newer than anything pending, so it wins.
      if (load_ok) begin
        period_d = period_in;
      end else if (pend_vld_q) begin
        period_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else begin
      if (boundary) begin
        tick_d       = '0;
        beat_d       = 1'b1;
        bar_d        = (next_idx_q == '0);
        beat_index_d = next_idx_q;
        next_idx_d   = (next_idx_q == LAST_IDX) ? '0 : next_idx_q + 1'b1;
        if (pend_vld_q) begin
          period_d   = pend_q;
          pend_vld_d = 1'b0;
        end
      end else if (enable) begin
        tick_d = tick_q + ONE_P;
      end
      // Evaluated after the boundary so a coincident load lands at the following boundary.
      if (load_ok) begin
        pend_d     = period_in;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q       <= '0;
      period_q     <= DEF_P;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      next_idx_q   <= '0;
      beat_index_q <= '0;
      beat_q       <= 1'b0;
      bar_q        <= 1'b0;
    end else begin
      tick_q       <= tick_d;
      period_q     <= period_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      next_idx_q   <= next_idx_d;
      beat_index_q <= beat_index_d;
      beat_q       <= beat_d;
      bar_q        <= bar_d;
    end
  end

  assign beat       = beat_q;
  assign bar        = bar_q;
  assign beat_index = beat_index_q;
  assign period     = period_q;

endmodule

// File: tb/tb_beat_generator.sv
// Bench for beat_generator: directed tempo scenarios with literal expectations plus a randomized run
// checked every cycle against an elapsed-cycle / beat-count reference model.
module tb_beat_generator;
  localparam int PW   = 8;
  localparam int DEFP = 4;
  localparam int BPB  = 4;
  localparam int BW   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          restart = 1'b0;
  logic          period_load = 1'b0;
  logic [PW-1:0] period_in = '0;
  logic          beat;
  logic          bar;
  logic [BW-1:0] beat_index;
  logic [PW-1:0] period;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  beat_generator #(
    .PERIOD_WIDTH(PW),
    .DEFAULT_PERIOD(DEFP),
    .BEATS_PER_BAR(BPB),
    .BAR_WIDTH(BW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .restart(restart),
    .period_load(period_load),
    .period_in(period_in),
    .beat(beat),
    .bar(bar),
    .beat_index(beat_index),
    .period(period)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts enabled cycles into the current interval and beats since the bar origin.
  bit m_valid = 1'b0;
  int m_elapsed, m_nbeats, m_period, m_pend;
  bit m_pend_v;
  bit m_ld_ok;
  bit e_beat, e_bar;
  int e_idx;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1'b1; m_elapsed = 0; m_nbeats = 0; m_pend = 0; m_pend_v = 1'b0;
      m_period = DEFP; e_beat = 1'b0; e_bar = 1'b0; e_idx = 0;
    end else if (m_valid) begin
      m_ld_ok = period_load && (int'(period_in) >= 2);
      e_beat = 1'b0;
      e_bar  = 1'b0;
      if (restart) begin
        m_elapsed = 0;
        m_nbeats  = 0;
        if (m_ld_ok) m_period = int'(period_in);
        else if (m_pend_v) m_period = m_pend;
        m_pend_v = 1'b0;
      end else begin
        if (enable) begin
          m_elapsed++;
          if (m_elapsed == m_period) begin
            m_elapsed = 0;
            e_beat = 1'b1;
            e_idx  = m_nbeats % BPB;
            e_bar  = (e_idx == 0);
            m_nbeats++;
            if (m_pend_v) begin
              m_period = m_pend;
              m_pend_v = 1'b0;
            end
          end
        end
        if (m_ld_ok) begin
          m_pend   = int'(period_in);
          m_pend_v = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_beat", 32'(beat), 32'(e_beat));
      check("model_bar", 32'(bar), 32'(e_bar));
      check("model_index", 32'(beat_index), 32'(e_idx));
      check("model_period", 32'(period), 32'(m_period));
    end
  end

  task automatic chk_out(input int ph, input int i, input int eb, input int ebar, input int eidx);
    check($sformatf("p%0d_c%0d_beat", ph, i), 32'(beat), 32'(eb));
    check($sformatf("p%0d_c%0d_bar", ph, i), 32'(bar), 32'(ebar));
    check($sformatf("p%0d_c%0d_index", ph, i), 32'(beat_index), 32'(eidx));
  endtask

  task automatic chk_b(input int ph, input int i, input int eb);
    check($sformatf("p%0d_c%0d_beat", ph, i), 32'(beat), 32'(eb));
  endtask

  task automatic chk_p(input int ph, input int i, input int ep);
    check($sformatf("p%0d_c%0d_period", ph, i), 32'(period), 32'(ep));
  endtask

  // Hand-derived expectations; i is the cycle number counted from reset release.
  task automatic lit(input int ph, input int i);
    case (ph)
      0: case (i)
           4:  chk_out(ph, i, 1, 1, 0);
           5:  chk_b(ph, i, 0);
           8:  chk_out(ph, i, 1, 0, 1);
           12: chk_out(ph, i, 1, 0, 2);
           16: chk_out(ph, i, 1, 0, 3);
           20: chk_out(ph, i, 1, 1, 0);
           default: ;
         endcase
      1: case (i)
           8:  chk_out(ph, i, 0, 0, 0);
           9:  chk_b(ph, i, 0);
           10: chk_b(ph, i, 0);
           11: chk_out(ph, i, 1, 0, 1);
           15: chk_out(ph, i, 1, 0, 2);
           default: ;
         endcase
      2: case (i)
           7:  chk_p(ph, i, 4);
           8:  begin chk_out(ph, i, 1, 0, 1); chk_p(ph, i, 6); end
           11: chk_b(ph, i, 0);
           14: chk_out(ph, i, 1, 0, 2);
           20: chk_out(ph, i, 1, 0, 3);
           21: chk_p(ph, i, 6);
           default: ;
         endcase
      3: case (i)
           4:  begin chk_out(ph, i, 1, 1, 0); chk_p(ph, i, 3); end
           7:  chk_out(ph, i, 1, 0, 1);
           10: begin chk_out(ph, i, 1, 0, 2); chk_p(ph, i, 3); end
           13: begin chk_out(ph, i, 1, 0, 3); chk_p(ph, i, 5); end
           18: chk_out(ph, i, 1, 1, 0);
           default: ;
         endcase
      4: case (i)
           4:  chk_out(ph, i, 1, 1, 0);
           7:  begin chk_out(ph, i, 0, 0, 0); chk_p(ph, i, 5); end
           8:  chk_b(ph, i, 0);
           12: chk_out(ph, i, 1, 1, 0);
           17: chk_out(ph, i, 1, 0, 1);
           21: chk_out(ph, i, 0, 0, 1);
           22: chk_b(ph, i, 0);
           25: chk_b(ph, i, 0);
           30: chk_out(ph, i, 1, 1, 0);
           default: ;
         endcase
      5: case (i)
           4:  begin chk_out(ph, i, 1, 1, 0); chk_p(ph, i, 2); end
           6:  chk_out(ph, i, 1, 0, 1);
           8:  chk_out(ph, i, 1, 0, 2);
           10: begin chk_out(ph, i, 0, 0, 0); chk_p(ph, i, 4); end
           14: begin chk_out(ph, i, 1, 1, 0); chk_p(ph, i, 4); end
           15: chk_p(ph, i, 4);
           default: ;
         endcase
      default: ;
    endcase
  endtask

  task automatic drive(input int ph, input int i);
    reset = 1'b0; enable = 1'b1; restart = 1'b0; period_load = 1'b0; period_in = '0;
    case (ph)
      1: if (i >= 6 && i <= 8) enable = 1'b0;
      2: begin
           if (i == 5)  begin period_load = 1'b1; period_in = 8'd6; end
           if (i == 15) begin period_load = 1'b1; period_in = 8'd1; end
         end
      3: begin
           if (i == 1) begin period_load = 1'b1; period_in = 8'd7; end
           if (i == 2) begin period_load = 1'b1; period_in = 8'd3; end
           if (i == 9) begin period_load = 1'b1; period_in = 8'd5; end
         end
      4: begin
           if (i == 5) begin period_load = 1'b1; period_in = 8'd5; end
           if (i == 6) restart = 1'b1;
           if (i == 20) restart = 1'b1;
           if (i >= 20 && i <= 24) enable = 1'b0;
         end
      5: begin
           if (i == 1) begin period_load = 1'b1; period_in = 8'd2; end
           if (i == 8) begin period_load = 1'b1; period_in = 8'd7; end
           if (i == 9) reset = 1'b1;
         end
      default: ;
    endcase
  endtask

  task automatic run_phase(input int ph, input int ncyc);
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; restart = 1'b0; period_load = 1'b0; period_in = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      lit(ph, i);
      drive(ph, i);
    end
  endtask

  initial begin
    run_phase(0, 22);
    run_phase(1, 17);
    run_phase(2, 23);
    run_phase(3, 20);
    run_phase(4, 32);
    run_phase(5, 17);

    @(negedge clk);
    reset = 1'b1; enable = 1'b0; restart = 1'b0; period_load = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset       = ($urandom_range(0, 299) == 0);
      enable      = ($urandom_range(0, 9) != 0);
      restart     = ($urandom_range(0, 39) == 0);
      period_load = ($urandom_range(0, 7) == 0);
      period_in   = PW'($urandom_range(0, 9));
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
